// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: data width, fetch FSM state encoding,
// canonical NOP word and a PC word-alignment helper.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } fetch_state_t;

  // Instruction fetch is word addressed; the low two address bits are forced to 0.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs between instruction memory and decode.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   i_push, i_wdata - write one entry
//   i_pop           - retire the head entry
//   i_flush         - drop all entries and rewind pointers (wins over push/pop)
//   o_rdata         - head entry (contents don't-care while empty)
//   o_count         - number of valid entries
//   o_empty         - registered empty flag
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH_C);
      if (i_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (i_push) begin
          r_mem[r_wr_ptr] <= i_wdata;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (i_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = r_empty;

  // The issue rule upstream reserves a slot for every in-flight read.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && r_full));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && !i_flush && r_empty));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer between decode and a 1-cycle-latency synchronous
// instruction memory. Issues sequential word reads, buffers returned words with
// their PC in a prefetch FIFO, flushes on redirect (dropping the in-flight read),
// and implements a halt/drain handshake. The memory never stalls mid-read.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   imem_addr, imem_renable    - read request to instruction memory
//   imem_rdata                 - read data, valid the cycle after imem_renable
//   redirect_valid/redirect_pc - flush and restart fetch at redirect_pc
//   instr_valid/data/pc        - FIFO head towards decode
//   dec_ready                  - decode accepts head
//   halt_req, halted           - halt request level / halted status
module imem_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_renable,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  input  logic        halt_req,
  output logic        halted
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;

  logic            w_run;
  logic            w_issue;
  logic            w_pop;
  logic            w_push;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic [2*XLEN-1:0] w_head;

  // Occupancy counts the in-flight read as already owning a FIFO slot.
  assign w_occ       = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign instr_valid = !w_fifo_empty;
  assign w_pop       = instr_valid & dec_ready & !redirect_valid;
  assign w_push      = r_inflight & !redirect_valid;
  // Gating with rst_n keeps the strobe low while reset is held.
  assign w_issue     = rst_n & w_run & !halt_req & !redirect_valid &
                       ((w_occ < DEPTH_V) | ((w_occ == DEPTH_V) & w_pop));

  assign imem_renable = w_issue;
  assign imem_addr    = r_fetch_pc;
  assign instr_pc     = w_head[2*XLEN-1:XLEN];
  assign instr_data   = w_head[XLEN-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (halt_req)    w_state_nxt = ST_HALTING;
      ST_HALTING: if (!r_inflight) w_state_nxt = ST_HALTED;
      ST_HALTED:  if (!halt_req)   w_state_nxt = ST_RUN;
      default:                     w_state_nxt = ST_RUN;
    endcase
  end

  // State outputs
  always_comb begin
    w_run  = (r_state == ST_RUN);
    halted = (r_state == ST_HALTED);
  end

  // Fetch PC and in-flight tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end
      if (redirect_valid) begin
        r_fetch_pc <= align_word(redirect_pc);
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata ({r_inflight_pc, imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_renable;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        dec_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        halted;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_renable   (imem_renable),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .dec_ready      (dec_ready),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  // Synchronous instruction memory, 1-cycle read latency
  always @(posedge clk) begin
    if (imem_renable) imem_rdata <= memword(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    dec_ready      = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nrd;

    // Reset state
    apply_reset();
    #1;
    chk("rst_valid",   32'(instr_valid),  32'd0);
    chk("rst_halted",  32'(halted),       32'd0);
    chk("rst_addr",    imem_addr,         32'h0);
    chk("rst_renable", 32'(imem_renable), 32'd0);

    // Streaming with decode always ready
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("s_addr",    imem_addr,         32'(c * 4));
      chk("s_renable", 32'(imem_renable), 32'd1);
      if (c >= 2) begin
        chk("s_valid", 32'(instr_valid), 32'd1);
        chk("s_pc",    instr_pc,         32'((c - 2) * 4));
        chk("s_data",  instr_data,       memword(32'((c - 2) * 4)));
      end else begin
        chk("s_valid0", 32'(instr_valid), 32'd0);
      end
      tick();
    end

    // Decode stalled: exactly FIFO_DEPTH reads, then resume on first pop
    apply_reset();
    rst_n     = 1'b1;
    dec_ready = 1'b0;
    nrd       = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (imem_renable) nrd++;
      tick();
    end
    chk("stall_reads", 32'(nrd), 32'd2);
    dec_ready = 1'b1;
    #1;
    chk("resume_renable", 32'(imem_renable), 32'd1);
    chk("resume_addr",    imem_addr,         32'h8);
    chk("resume_pc",      instr_pc,          32'h0);
    tick(); #1;
    chk("resume_addr2",   imem_addr,         32'hC);
    chk("resume_pc2",     instr_pc,          32'h4);
    tick(); #1;
    chk("resume_valid3",  32'(instr_valid),  32'd1);
    chk("resume_pc3",     instr_pc,          32'h8);

    // Redirect with occupancy full (1 entry + 1 read in flight)
    apply_reset();
    rst_n     = 1'b1;
    dec_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("rd_pre_valid",   32'(instr_valid),  32'd1);
    chk("rd_renable",     32'(imem_renable), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_valid1",      32'(instr_valid),  32'd0);
    chk("rd_addr1",       imem_addr,         32'h100);
    chk("rd_renable1",    32'(imem_renable), 32'd1);
    tick(); #1;
    chk("rd_valid2",      32'(instr_valid),  32'd0);
    chk("rd_addr2",       imem_addr,         32'h104);
    tick(); #1;
    chk("rd_valid3",      32'(instr_valid),  32'd1);
    chk("rd_pc3",         instr_pc,          32'h100);
    chk("rd_data3",       instr_data,        memword(32'h100));

    // Halt while streaming, drain, resume
    apply_reset();
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    halt_req = 1'b1;
    #1;
    chk("h_renable0", 32'(imem_renable), 32'd0);
    chk("h_halted0",  32'(halted),       32'd0);
    chk("h_pc0",      instr_pc,          32'h8);
    tick(); #1;
    chk("h_valid1",   32'(instr_valid),  32'd1);
    chk("h_pc1",      instr_pc,          32'hC);
    chk("h_halted1",  32'(halted),       32'd0);
    chk("h_renable1", 32'(imem_renable), 32'd0);
    tick(); #1;
    chk("h_halted2",  32'(halted),       32'd1);
    chk("h_valid2",   32'(instr_valid),  32'd0);
    tick();
    halt_req = 1'b0;
    #1;
    chk("h_halted3",  32'(halted),       32'd1);
    chk("h_renable3", 32'(imem_renable), 32'd0);
    tick(); #1;
    chk("h_halted4",  32'(halted),       32'd0);
    chk("h_renable4", 32'(imem_renable), 32'd1);
    chk("h_addr4",    imem_addr,         32'h10);
    tick();
    tick(); #1;
    chk("h_valid6",   32'(instr_valid),  32'd1);
    chk("h_pc6",      instr_pc,          32'h10);

    // Address wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    #1;
    chk("w_renable0", 32'(imem_renable), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("w_addr1",    imem_addr,         32'hFFFF_FFFC);
    chk("w_renable1", 32'(imem_renable), 32'd1);
    tick(); #1;
    chk("w_addr2",    imem_addr,         32'h0);
    tick(); #1;
    chk("w_pc3",      instr_pc,          32'hFFFF_FFFC);
    chk("w_data3",    instr_data,        memword(32'hFFFF_FFFC));
    tick(); #1;
    chk("w_pc4",      instr_pc,          32'h0);

    // Reset while one entry is buffered and a read is in flight
    apply_reset();
    rst_n     = 1'b1;
    dec_ready = 1'b0;
    tick();
    tick();
    chk("r_pre_valid", 32'(instr_valid), 32'd1);
    rst_n = 1'b0;
    tick(); #1;
    chk("r_valid",     32'(instr_valid),  32'd0);
    chk("r_addr",      imem_addr,         32'h0);
    chk("r_renable",   32'(imem_renable), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("r_renable1",  32'(imem_renable), 32'd1);
    chk("r_addr1",     imem_addr,         32'h0);
    tick(); #1;
    chk("r_valid2",    32'(instr_valid),  32'd0);
    tick(); #1;
    chk("r_valid3",    32'(instr_valid),  32'd1);
    chk("r_pc3",       instr_pc,          32'h0);
    chk("r_data3",     instr_data,        32'h0000_0013);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
